// File: rtl/wb_tone_regs.sv
// wb_tone_regs: Wishbone register window controlling a tone generator.
// Holds enable, phase increment, volume, scratch, ID and a sample-tick counter.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   wb_stbi         - wishbone strobe from initiator
//   wb_adri[7:0]    - wishbone address; [7:3] window select, [2:0] offset
//   wb_rwi          - 1 = write, 0 = read
//   wb_dati[7:0]    - write data
//   wb_acko         - registered single-cycle ack
//   wb_dato[7:0]    - registered read data, held until the next read
//   sample_tick     - one-cycle pulse per audio sample
//   tone_en         - tone generator enable (CTRL bit0)
//   phase_inc[15:0] - committed phase increment
//   volume[7:0]     - output amplitude scale
//
// Define WB_TONE_WAIT_STATE_EN to insert one wait state before each ack.

module wb_tone_regs #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] ID_VALUE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stbi,
    input  logic [7:0]  wb_adri,
    input  logic        wb_rwi,
    input  logic [7:0]  wb_dati,
    output logic        wb_acko,
    output logic [7:0]  wb_dato,
    input  logic        sample_tick,
    output logic        tone_en,
    output logic [15:0] phase_inc,
    output logic [7:0]  volume
);

    logic        hit;
    logic [2:0]  offset;
    logic        xfer;
    logic        wr;
    logic        rd;
    logic        cnt_clr;
    logic [7:0]  staged_lo;
    logic [7:0]  scratch;
    logic [7:0]  cnt_hi;
    logic [15:0] count;
    logic [7:0]  rd_data;

    assign hit    = wb_stbi & (wb_adri[7:3] == BASE_ADDR[7:3]);
    assign offset = wb_adri[2:0];

`ifdef WB_TONE_WAIT_STATE_EN
    // pend marks the wait cycle; the access happens only if the
    // strobe is still present when the wait cycle ends.
    logic pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= hit & ~wb_acko & ~pend;
        end
    end

    assign xfer = pend & hit;
`else
    // Blocking on wb_acko prevents a second ack for a held strobe.
    assign xfer = hit & ~wb_acko;
`endif

    assign wr      = xfer & wb_rwi;
    assign rd      = xfer & ~wb_rwi;
    assign cnt_clr = wr & (offset == 3'd0) & wb_dati[1];

    always_comb begin
        rd_data = 8'h00;
        unique case (offset)
            3'd0: rd_data = {7'b0, tone_en};
            3'd1: rd_data = staged_lo;
            3'd2: rd_data = phase_inc[15:8];
            3'd3: rd_data = volume;
            3'd4: rd_data = count[7:0];
            3'd5: rd_data = cnt_hi;
            3'd6: rd_data = scratch;
            3'd7: rd_data = ID_VALUE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_acko <= 1'b0;
            wb_dato <= 8'h00;
        end else begin
            wb_acko <= xfer;
            if (rd) begin
                wb_dato <= rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_en   <= 1'b0;
            staged_lo <= 8'h00;
            phase_inc <= 16'h0000;
            volume    <= 8'h00;
            scratch   <= 8'h00;
        end else if (wr) begin
            unique case (offset)
                3'd0: tone_en   <= wb_dati[0];
                3'd1: staged_lo <= wb_dati;
                3'd2: phase_inc <= {wb_dati, staged_lo};
                3'd3: volume    <= wb_dati;
                3'd6: scratch   <= wb_dati;
                default: ;
            endcase
        end
    end

    // Clear beats a coincident tick. A CNT_LO read sees the
    // pre-increment count and snapshots its high byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 16'h0000;
            cnt_hi <= 8'h00;
        end else begin
            if (cnt_clr) begin
                count <= 16'h0000;
            end else if (sample_tick & tone_en) begin
                count <= count + 16'd1;
            end
            if (rd && offset == 3'd4) begin
                cnt_hi <= count[15:8];
            end
        end
    end

endmodule

// File: doc/wb_tone_regs.md
WB_TONE_REGS -- requirements
Module: wb_tone_regs

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: bits [7:3] select this block's 8-register window.
REQ-002 Parameter ID_VALUE, default 8'hA5: constant returned by the ID register.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  system reset, asynchronous, active-high.
REQ-005 wb_stbi  input  1  wishbone STB from initiator.
REQ-006 wb_adri  input  8  wishbone address.
REQ-007 wb_rwi  input  1  wishbone read/write: 1 = write, 0 = read.
REQ-008 wb_dati  input  8  wishbone write data.
REQ-009 wb_acko  output  1  wishbone ACK, registered, single-cycle pulse.
REQ-010 wb_dato  output  8  wishbone read data, registered.
REQ-011 sample_tick  input  1  one-cycle pulse per audio sample.
REQ-012 tone_en  output  1  tone generator enable (CTRL bit0).
REQ-013 phase_inc  output  16  committed phase increment.
REQ-014 volume  output  8  output amplitude scale.

Function
REQ-015 Selection: hit = wb_stbi & (wb_adri[7:3] == BASE_ADDR[7:3]); offset = wb_adri[2:0].
REQ-016 Map: 0 CTRL RW; 1 PHASE_LO RW staging; 2 PHASE_HI RW; 3 VOLUME RW; 4 CNT_LO RO; 5 CNT_HI RO snapshot; 6 SCRATCH RW; 7 ID RO.
REQ-017 Handshake: a hit first sampled high at edge N drives wb_acko high for exactly the cycle after edge N, then low.
REQ-018 No re-ack: wb_acko asserts only when wb_acko is currently low; strobe still high in the cycle following the ack produces no second ack.
REQ-019 Write effect: register updates on the same edge that raises wb_acko; read data is loaded into wb_dato on that same edge and held until the next read.
REQ-020 Miss (address outside window): no ack and no state change; the initiator's timeout ends the cycle.
REQ-021 Writes to offsets 4, 5, 7: acked, ignored.
REQ-022 CTRL: bit0 = tone_en; bit1 = counter clear, self-clearing, reads 0; bits [7:2] read 0.
REQ-023 PHASE_LO write stages a byte only; PHASE_HI write commits phase_inc = {wb_dati, staged_lo} atomically; reading PHASE_LO returns the staged byte and reading PHASE_HI returns phase_inc[15:8].
REQ-024 Tick counter: 16-bit, increments on sample_tick while tone_en = 1, wraps 16'hFFFF -> 16'h0000.
REQ-025 Reading CNT_LO returns count[7:0] and snapshots count[15:8] into CNT_HI on the same edge; CNT_HI reads return the snapshot.
REQ-026 Simultaneous counter clear and sample_tick: clear wins, count = 0.
REQ-027 Simultaneous CNT_LO read and tick: read returns the pre-increment value, and the snapshot matches that value.

Reset
REQ-028 On rst high, asynchronously: wb_acko = 0, wb_dato = 8'h00, tone_en = 0, phase_inc = 16'h0000, volume = 8'h00, staged_lo = 0, SCRATCH = 0, count = 0, CNT_HI snapshot = 0, wait-state tracking cleared.
REQ-029 Reset during a pending or acked transfer aborts it; after release, a still-high wb_stbi is treated as a new transfer.

Configuration
REQ-030 Macro WB_TONE_WAIT_STATE_EN defined: one wait state, so wb_acko rises two cycles after the hit is first sampled and the write/read edge moves with it; the transfer is dropped with no ack if wb_stbi falls during the wait.
REQ-031 Macro undefined: zero wait states, per REQ-017.

Verification
REQ-032 Write 0x34 to offset 1, then 0x12 to offset 2 -> phase_inc stays 0x0000 after the first write and becomes 0x1234 on the second ack edge; one ack pulse per transfer.
REQ-033 Read offset 7 with ID_VALUE default -> wb_dato = 0xA5 with a single-cycle ack; stb held one extra cycle -> no second ack.
REQ-034 Address 0x08 with BASE_ADDR = 0x00 -> no ack for 16+ cycles, and all registers are unchanged.
REQ-035 Enable, then apply 0x10001 ticks -> CNT_LO = 0x01 and CNT_HI = 0x00 after wrap; write CTRL = 0x03 with a coincident tick -> count = 0 and CTRL reads 0x01.
REQ-036 Assert rst one cycle after a write ack begins -> wb_acko drops immediately and volume = 0x00; with WB_TONE_WAIT_STATE_EN defined, ack latency measures 2 cycles.
